// File: rtl/lock_seq_defs_pkg.sv
// Shared definitions for the code-lock sequencer: state encoding,
// default parameter values, stats width and timer sizing helpers.
package lock_seq_defs_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_WAIT    = 3'd2,
    S_FLUSH   = 3'd3,
    S_OPEN    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;

  localparam int DEF_CODE_W         = 4;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_RESP_TIMEOUT   = 4;
  localparam int DEF_FLUSH_CYCLES   = 2;
  localparam int DEF_RELOCK_CYCLES  = 32;
  localparam int DEF_LOCKOUT_CYCLES = 64;
  localparam int STATS_W            = 16;

  function automatic int max4(input int a, input int b,
                              input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Timers are loaded with N-1, so N itself always fits.
  function automatic int tmr_width(input int a, input int b,
                                   input int c, input int d);
    int w;
    w = $clog2(max4(a, b, c, d) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lock_seq_timer.sv
// Loadable down-counter that stops at zero; done is high while the
// count is zero. Shared by the response, flush, open and lockout phases.
module lock_seq_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Feeds keypad codes MSB-first into the serial lock detector and judges
// its reply. LOCK_SEQ_STATS_EN adds attempt/lockout counters.
module lock_sequencer
  import lock_seq_defs_pkg::*;
#(
  parameter int CODE_W         = DEF_CODE_W,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int RESP_TIMEOUT   = DEF_RESP_TIMEOUT,
  parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
  parameter int RELOCK_CYCLES  = DEF_RELOCK_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  localparam int FW = $clog2(MAX_FAILS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_data,
  output logic              code_ready,
  output logic              lock_in,
  input  logic              lock_error,
  input  logic              lock_unlock,
  output logic              result_valid,
  output logic              result_ok,
  output logic              door_open,
  output logic              locked_out,
`ifdef LOCK_SEQ_STATS_EN
  output logic [STATS_W-1:0] attempt_count,
  output logic [STATS_W-1:0] lockout_count,
`endif
  output logic [FW-1:0]     fail_count
);

  localparam int TW = tmr_width(RESP_TIMEOUT, FLUSH_CYCLES,
                                RELOCK_CYCLES, LOCKOUT_CYCLES);
  localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  localparam logic [TW-1:0] T_RESP  = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] T_FLUSH = TW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] T_OPEN  = TW'(RELOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] F_MAX   = FW'(MAX_FAILS);

  state_e state_q, state_d;

  logic [CODE_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              lock_in_q, lock_in_d;
  logic              rv_q, rv_d;
  logic              ok_q, ok_d;
  logic [FW-1:0]     fc_q, fc_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  logic          accept;
  logic          in_wait;
  logic          go_ok;
  logic          go_fail;
  logic [FW-1:0] fc_inc;
  logic          to_lockout;

  lock_seq_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  assign accept     = (state_q == S_IDLE) && code_valid;
  assign in_wait    = (state_q == S_WAIT);
  // Error dominates; silence until the timer drains also counts as failure.
  assign go_fail    = in_wait &&
                      (lock_error || (!lock_unlock && tmr_done));
  assign go_ok      = in_wait && !lock_error && lock_unlock;
  assign fc_inc     = (fc_q == F_MAX) ? fc_q : fc_q + 1'b1;
  assign to_lockout = go_fail && (fc_inc == F_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_cnt_q == '0) begin
          state_d  = S_WAIT;
          tmr_load = 1'b1;
          tmr_val  = T_RESP;
        end
      end
      S_WAIT: begin
        if (go_ok) begin
          state_d  = S_OPEN;
          tmr_load = 1'b1;
          tmr_val  = T_OPEN;
        end else if (to_lockout) begin
          state_d  = S_LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = T_LOCK;
        end else if (go_fail) begin
          state_d  = S_FLUSH;
          tmr_load = 1'b1;
          tmr_val  = T_FLUSH;
        end
      end
      S_OPEN, S_LOCKOUT: begin
        if (tmr_done) begin
          state_d  = S_FLUSH;
          tmr_load = 1'b1;
          tmr_val  = T_FLUSH;
        end
      end
      S_FLUSH: begin
        if (tmr_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    lock_in_d = 1'b0;
    rv_d      = go_ok || go_fail;
    ok_d      = go_ok;
    fc_d      = fc_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          lock_in_d = code_data[CODE_W-1];
          sh_d      = code_data << 1;
          bit_cnt_d = BW'(CODE_W - 1);
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q != '0) begin
          lock_in_d = sh_q[CODE_W-1];
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (go_ok) fc_d = '0;
        else if (go_fail) fc_d = fc_inc;
      end
      S_LOCKOUT: begin
        if (tmr_done) fc_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q      <= '0;
      bit_cnt_q <= '0;
      lock_in_q <= 1'b0;
      rv_q      <= 1'b0;
      ok_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      lock_in_q <= lock_in_d;
      rv_q      <= rv_d;
      ok_q      <= ok_d;
      fc_q      <= fc_d;
    end
  end

  assign code_ready   = (state_q == S_IDLE);
  assign door_open    = (state_q == S_OPEN);
  assign locked_out   = (state_q == S_LOCKOUT);
  assign lock_in      = lock_in_q;
  assign result_valid = rv_q;
  assign result_ok    = ok_q;
  assign fail_count   = fc_q;

`ifdef LOCK_SEQ_STATS_EN
  logic [STATS_W-1:0] att_q, att_d;
  logic [STATS_W-1:0] lko_q, lko_d;

  always_comb begin
    att_d = att_q;
    lko_d = lko_q;
    if (rv_d && (att_q != '1)) att_d = att_q + 1'b1;
    if (to_lockout && (lko_q != '1)) lko_d = lko_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      att_q <= '0;
      lko_q <= '0;
    end else begin
      att_q <= att_d;
      lko_q <= lko_d;
    end
  end

  assign attempt_count = att_q;
  assign lockout_count = lko_q;
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a simple 4-bit detector model.
// Covers success, error, timeout, lockout and mid-shift reset.
module tb_lock_sequencer;

  logic       clk;
  logic       reset;
  logic       code_valid;
  logic [3:0] code_data;
  logic       code_ready;
  logic       lock_in;
  logic       lock_error;
  logic       lock_unlock;
  logic       result_valid;
  logic       result_ok;
  logic       door_open;
  logic       locked_out;
  logic [1:0] fail_count;
`ifdef LOCK_SEQ_STATS_EN
  logic [15:0] attempt_count;
  logic [15:0] lockout_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // 0: silent, 1: shift-register detector, 2: error+unlock together
  int         det_mode;
  logic [3:0] det_sh;

  lock_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .code_data   (code_data),
    .code_ready  (code_ready),
    .lock_in     (lock_in),
    .lock_error  (lock_error),
    .lock_unlock (lock_unlock),
    .result_valid(result_valid),
    .result_ok   (result_ok),
    .door_open   (door_open),
    .locked_out  (locked_out),
`ifdef LOCK_SEQ_STATS_EN
    .attempt_count(attempt_count),
    .lockout_count(lockout_count),
`endif
    .fail_count  (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) det_sh <= {det_sh[2:0], lock_in};

  assign lock_unlock = (det_mode == 1) ? (det_sh == 4'b1011)
                                       : (det_mode == 2);
  assign lock_error  = (det_mode == 1) ?
                       ((det_sh != 4'b1011) && (det_sh != 4'b0000))
                       : (det_mode == 2);

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake, then check MSB..LSB on lock_in; ends in cycle T+4.
  task automatic send_code(input logic [3:0] c);
    logic [3:0] v;
    v = c;
    @(negedge clk);
    check_eq("ready_before", int'(code_ready), 1);
    code_valid = 1'b1;
    code_data  = v;
    tick();
    code_valid = 1'b0;
    check_eq("ready_in_shift", int'(code_ready), 0);
    for (int i = 3; i >= 0; i--) begin
      if (i != 3) tick();
      check_eq("lock_in_bit", int'(lock_in), int'(v[i]));
    end
  endtask

  // Result pulse expected 'lat' cycles after WAIT_RESP entry.
  task automatic wait_result(input int lat, input int ok, input int fc);
    for (int i = 0; i < lat; i++) begin
      tick();
      check_eq("no_early_result", int'(result_valid), 0);
      check_eq("wait_lock_in", int'(lock_in), 0);
    end
    tick();
    check_eq("result_valid", int'(result_valid), 1);
    check_eq("result_ok", int'(result_ok), ok);
    check_eq("fail_count", int'(fail_count), fc);
  endtask

  // From the fail pulse cycle (flush #1): one more flush cycle, then idle.
  task automatic after_fail();
    check_eq("flush_ready0", int'(code_ready), 0);
    tick();
    check_eq("flush2_ready0", int'(code_ready), 0);
    check_eq("flush2_lock_in", int'(lock_in), 0);
    check_eq("pulse_one_cycle", int'(result_valid), 0);
    tick();
    check_eq("ready_back", int'(code_ready), 1);
  endtask

  int n;

  initial begin
    reset      = 1'b1;
    code_valid = 1'b0;
    code_data  = 4'd0;
    det_mode   = 0;
    det_sh     = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_ready", int'(code_ready), 1);
    check_eq("rst_lock_in", int'(lock_in), 0);
    check_eq("rst_rv", int'(result_valid), 0);
    check_eq("rst_ok", int'(result_ok), 0);
    check_eq("rst_door", int'(door_open), 0);
    check_eq("rst_locked", int'(locked_out), 0);
    check_eq("rst_fc", int'(fail_count), 0);
    tick();

    // Correct code: open for 32 cycles, 2 flush cycles, idle.
    det_mode = 1;
    send_code(4'b1011);
    wait_result(1, 1, 0);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (i != 0) tick();
      if (door_open && !code_ready) n++;
    end
    check_eq("door_open_len", n, 32);
    tick();
    check_eq("door_closed", int'(door_open), 0);
    check_eq("open_flush1_ready", int'(code_ready), 0);
    check_eq("open_flush1_lock_in", int'(lock_in), 0);
    tick();
    check_eq("open_flush2_ready", int'(code_ready), 0);
    tick();
    check_eq("open_idle_ready", int'(code_ready), 1);

    // Wrong code with ERROR.
    send_code(4'b1001);
    wait_result(1, 0, 1);
    check_eq("no_lockout_1", int'(locked_out), 0);
    after_fail();

    // Silent detector: timeout after 4 samples.
    det_mode = 0;
    send_code(4'b0110);
    wait_result(4, 0, 2);
    after_fail();

    // Right code after two failures clears the count.
    det_mode = 1;
    send_code(4'b1011);
    wait_result(1, 1, 0);
    check_eq("no_lockout_wwr", int'(locked_out), 0);
    repeat (34) tick();
    check_eq("wwr_idle", int'(code_ready), 1);

    // Three failures: error, error, error+unlock together.
    send_code(4'b1001);
    wait_result(1, 0, 1);
    after_fail();
    send_code(4'b0011);
    wait_result(1, 0, 2);
    after_fail();
    det_mode = 2;
    send_code(4'b1011);
    wait_result(1, 0, 3);
    det_mode   = 0;
    code_valid = 1'b1;
    code_data  = 4'b1011;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (i != 0) tick();
      if (locked_out && !code_ready && !lock_in) n++;
    end
    check_eq("lockout_len", n, 64);
    tick();
    check_eq("lockout_exit", int'(locked_out), 0);
    check_eq("lockout_fc_clear", int'(fail_count), 0);
    check_eq("lockout_flush1_ready", int'(code_ready), 0);
    tick();
    check_eq("lockout_flush2_ready", int'(code_ready), 0);
    code_valid = 1'b0;
    tick();
    check_eq("lockout_idle_ready", int'(code_ready), 1);

    // Build fail_count=1, then reset in the middle of shifting 1111.
    det_mode = 1;
    send_code(4'b1001);
    wait_result(1, 0, 1);
    after_fail();
    @(negedge clk);
    code_valid = 1'b1;
    code_data  = 4'b1111;
    tick();
    code_valid = 1'b0;
    check_eq("pre_rst_lock_in", int'(lock_in), 1);
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_lock_in", int'(lock_in), 0);
    check_eq("mid_rst_ready", int'(code_ready), 1);
    check_eq("mid_rst_rv", int'(result_valid), 0);
    check_eq("mid_rst_ok", int'(result_ok), 0);
    check_eq("mid_rst_fc", int'(fail_count), 0);
    check_eq("mid_rst_door", int'(door_open), 0);
    check_eq("mid_rst_locked", int'(locked_out), 0);
`ifdef LOCK_SEQ_STATS_EN
    check_eq("mid_rst_attempts", int'(attempt_count), 0);
    check_eq("mid_rst_lockouts", int'(lockout_count), 0);
`endif
    reset = 1'b0;
    tick();
    check_eq("post_rst_lock_in", int'(lock_in), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
